// File: rtl/edge_event_pkg.sv
// Shared types and helpers for the multi-channel edge-event capture block.
// The mode encoding matches the two-bit per-channel field on the top-level mode bus.
package edge_event_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int DEF_CHANNELS    = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE    = 4;

    // Width of a counter that must hold values 0..debounce.
    function automatic int cnt_width(input int debounce);
        return (debounce < 1) ? 1 : $clog2(debounce + 1);
    endfunction

    // True when a transition to new_level should be reported under mode m.
    function automatic logic edge_qualifies(input edge_mode_t m, input logic new_level);
        logic q;
        case (m)
            EDGE_RISE: q = new_level;
            EDGE_FALL: q = !new_level;
            EDGE_BOTH: q = 1'b1;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_event_chan.sv
// One capture channel: synchroniser chain, debounce counter, accepted level
// and a registered one-cycle pulse for qualified edges.
module edge_event_chan
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  edge_mode_t mode,
    output logic       level,
    output logic       pulse
);

    localparam int            CW       = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          r_sync [SYNC_STAGES];
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_pulse;

    logic          w_s;
    logic [CW-1:0] w_cnt_next;
    logic          w_level_next;
    logic          w_pulse_next;

    // Reset loads the raw input straight into every stage so that the
    // synchronised value already agrees with level and no edge is seen.
    always_ff @(posedge clk) begin
        r_sync[0] <= a;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) r_sync[gi] <= a;
                else     r_sync[gi] <= r_sync[gi-1];
            end
        end
    endgenerate

    assign w_s = r_sync[SYNC_STAGES-1];

    // Any return of s to level restarts the count; acceptance happens on the
    // DEBOUNCE-th consecutive differing sample.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        w_pulse_next = 1'b0;
        if (w_s == r_level) begin
            w_cnt_next = '0;
        end else if (r_cnt >= CNT_LAST) begin
            w_cnt_next   = '0;
            w_level_next = w_s;
            w_pulse_next = edge_qualifies(mode, w_s);
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= a;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_pulse <= w_pulse_next;
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule

// File: rtl/edge_event.sv
// Multi-channel edge-event capture: per-channel debounce/qualification plus
// sticky pending and overrun flags that software or an FSM polls and clears.
module edge_event
    import edge_event_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   a,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic                  any_pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic [CHANNELS-1:0]   overrun
);

    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_pulse;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_overrun;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            edge_event_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE    (DEBOUNCE)
            ) u_chan (
                .clk   (clk),
                .rst   (rst),
                .a     (a[gi]),
                .mode  (edge_mode_t'(mode[2*gi +: 2])),
                .level (w_level[gi]),
                .pulse (w_pulse[gi])
            );

            // A new event always wins over a simultaneous clear so none is lost.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pending[gi] <= 1'b0;
                    r_overrun[gi] <= 1'b0;
                end else if (w_pulse[gi]) begin
                    r_pending[gi] <= 1'b1;
                    if (r_pending[gi]) r_overrun[gi] <= 1'b1;
                end else if (clr[gi]) begin
                    r_pending[gi] <= 1'b0;
                    r_overrun[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign level     = w_level;
    assign pulse     = w_pulse;
    assign any_pulse = |w_pulse;
    assign pending   = r_pending;
    assign overrun   = r_overrun;

endmodule
